// File: rtl/addsub_serial_seq.sv
// Bit-serial add/subtract sequencer. One full-adder cell is reused for WIDTH
// cycles, LSB first. A start/done handshake accepts operands. The result,
// carry-out and signed overflow are registered and held until the next op
// completes.

// Single full-adder cell: the only arithmetic in the datapath.
module addsub_serial_fa (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic c_o
);
  assign s_o = a_i ^ b_i ^ c_i;
  assign c_o = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);
endmodule

module addsub_serial_seq #(
  parameter int WIDTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             sub_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o,
  output logic             cout_o,
  output logic             ovf_o
);

  localparam int CW = $clog2(WIDTH);

  // The last bit index finishes the op. The one before it yields the carry
  // into the MSB, which is needed for signed overflow.
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_PEN  = CW'(WIDTH - 2);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state_q,  state_d;
  logic [WIDTH-1:0] a_sh_q,   a_sh_d;
  logic [WIDTH-1:0] b_sh_q,   b_sh_d;
  logic [WIDTH-1:0] acc_q,    acc_d;
  logic [CW-1:0]    cnt_q,    cnt_d;
  logic             carry_q,  carry_d;
  logic             cmsb_q,   cmsb_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             cout_q,   cout_d;
  logic             ovf_q,    ovf_d;

  logic fa_s, fa_c;

  // B is inverted on entry for subtraction, so the cell always adds. Its
  // carry-in is seeded with sub to complete the two's complement.
  addsub_serial_fa u_fa (
    .a_i (a_sh_q[0]),
    .b_i (b_sh_q[0]),
    .c_i (carry_q),
    .s_o (fa_s),
    .c_o (fa_c)
  );

  // Next-state: accept in IDLE/DONE, one bit per cycle in RUN, retire on last bit.
  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    carry_d  = carry_q;
    cmsb_d   = cmsb_q;
    result_d = result_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_i) begin
          a_sh_d  = a_i;
          b_sh_d  = b_i ^ {WIDTH{sub_i}};
          acc_d   = '0;
          carry_d = sub_i;
          cmsb_d  = 1'b0;
          cnt_d   = '0;
          state_d = S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        a_sh_d  = a_sh_q >> 1;
        b_sh_d  = b_sh_q >> 1;
        acc_d   = {fa_s, acc_q[WIDTH-1:1]};
        carry_d = fa_c;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == CNT_PEN) cmsb_d = fa_c;
        if (cnt_q == CNT_LAST) begin
          result_d = acc_d;
          cout_d   = fa_c;
          ovf_d    = cmsb_q ^ fa_c;
          state_d  = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset abandons any in-flight op.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      cmsb_q   <= 1'b0;
      result_q <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      carry_q  <= carry_d;
      cmsb_q   <= cmsb_d;
      result_q <= result_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
    end
  end

  assign busy_o   = (state_q == S_RUN);
  assign done_o   = (state_q == S_DONE);
  assign result_o = result_q;
  assign cout_o   = cout_q;
  assign ovf_o    = ovf_q;

endmodule

// File: tb/tb_addsub_serial_seq.sv
// Bench for addsub_serial_seq (WIDTH=4). It uses a vector table, hand-written
// corner sequences and random ops. Expected results come from a scoreboard
// queue that is filled at issue time.
module tb_addsub_serial_seq;
  localparam int W = 4;

  typedef struct {
    logic [W-1:0] r;
    logic         c;
    logic         o;
  } exp_t;

  typedef struct {
    logic         sub;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] r;
    logic         c;
    logic         o;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         sub = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy, done, cout, ovf;
  logic [W-1:0] result;

  int   pass_cnt = 0;
  int   total_cnt = 0;
  exp_t sb[$];
  vec_t vecs[6];

  addsub_serial_seq #(.WIDTH(W)) dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .start_i  (start),
    .sub_i    (sub),
    .a_i      (a),
    .b_i      (b),
    .busy_o   (busy),
    .done_o   (done),
    .result_o (result),
    .cout_o   (cout),
    .ovf_o    (ovf)
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic exp_t model(input logic s, input logic [W-1:0] av, input logic [W-1:0] bv);
    exp_t e;
    logic [W:0] full;
    full = {1'b0, av} + {1'b0, bv ^ {W{s}}} + {{W{1'b0}}, s};
    e.r = full[W-1:0];
    e.c = full[W];
    if (s) e.o = (av[W-1] != bv[W-1]) && (full[W-1] != av[W-1]);
    else   e.o = (av[W-1] == bv[W-1]) && (full[W-1] != av[W-1]);
    return e;
  endfunction

  // Caller is at a negedge; start is sampled at the next posedge.
  task automatic issue(input logic s, input logic [W-1:0] av, input logic [W-1:0] bv, input exp_t e);
    sb.push_back(e);
    sub = s; a = av; b = bv; start = 1'b1;
  endtask

  // Runs one op from the start edge to its done cycle. Operands are scrambled
  // after the start edge. poke>=0 pulses start with junk operands at that
  // RUN cycle. The task returns at the negedge in the done cycle.
  task automatic finish_op(input int poke);
    int lat, bcnt;
    logic stable;
    logic [W-1:0] r0;
    exp_t e;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    a = W'($urandom); b = W'($urandom); sub = 1'($urandom);
    lat = 0; bcnt = 0; stable = 1'b1; r0 = result;
    while (!done && lat < 3 * W) begin
      if (busy) bcnt++;
      if (result !== r0) stable = 1'b0;
      if (lat == poke) begin
        start = 1'b1; a = '1; b = '1; sub = 1'b0;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    chk("latency", lat, W);
    chk("busy_cycles", bcnt, W);
    chk("result_stable_while_busy", {31'd0, stable}, 32'd1);
    if (done) begin
      chk("busy_in_done", {31'd0, busy}, 32'd0);
      if (sb.size() == 0) begin
        chk("scoreboard_nonempty", 32'd0, 32'd1);
      end else begin
        e = sb.pop_front();
        chk("result", {28'd0, result}, {28'd0, e.r});
        chk("cout", {31'd0, cout}, {31'd0, e.c});
        chk("ovf", {31'd0, ovf}, {31'd0, e.o});
      end
    end
  endtask

  initial begin
    int dcnt;
    logic s;
    logic [W-1:0] av, bv;
    vecs[0] = '{1'b0, 4'h3, 4'h5, 4'h8, 1'b0, 1'b1};
    vecs[1] = '{1'b1, 4'h5, 4'h3, 4'h2, 1'b1, 1'b0};
    vecs[2] = '{1'b1, 4'h3, 4'h5, 4'hE, 1'b0, 1'b0};
    vecs[3] = '{1'b0, 4'hF, 4'h1, 4'h0, 1'b1, 1'b0};
    vecs[4] = '{1'b0, 4'h8, 4'h8, 4'h0, 1'b1, 1'b1};
    vecs[5] = '{1'b1, 4'h7, 4'h2, 4'h5, 1'b1, 1'b0};

    // Reset state
    #12;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_result", {28'd0, result}, 32'd0);
    chk("rst_cout", {31'd0, cout}, 32'd0);
    chk("rst_ovf", {31'd0, ovf}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Table vectors, each separated by an idle cycle
    for (int i = 0; i < 6; i++) begin
      issue(vecs[i].sub, vecs[i].a, vecs[i].b, '{vecs[i].r, vecs[i].c, vecs[i].o});
      finish_op(-1);
      @(negedge clk);
    end

    // Start pulsed during RUN is ignored
    issue(1'b0, 4'h3, 4'h5, '{4'h8, 1'b0, 1'b1});
    finish_op(1);
    @(negedge clk);
    chk("no_op_after_ignored_start", {31'd0, busy | done}, 32'd0);

    // Back-to-back: start is held in the DONE cycle and the next op has no idle gap
    issue(1'b1, 4'h5, 4'h3, '{4'h2, 1'b1, 1'b0});
    finish_op(-1);
    issue(1'b0, 4'hF, 4'h1, '{4'h0, 1'b1, 1'b0});
    finish_op(-1);
    @(negedge clk);

    // Reset mid-RUN after two bits: outputs clear at once and no done follows
    issue(1'b0, 4'hF, 4'hF, '{4'hE, 1'b1, 1'b0});
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    rst = 1'b1;
    void'(sb.pop_back());
    #1;
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_result", {28'd0, result}, 32'd0);
    chk("midrst_cout", {31'd0, cout}, 32'd0);
    chk("midrst_ovf", {31'd0, ovf}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    dcnt = 0;
    for (int i = 0; i < W + 3; i++) begin
      @(negedge clk);
      if (done || busy) dcnt++;
    end
    chk("no_done_after_rst", dcnt, 0);
    issue(1'b1, 4'h7, 4'h2, '{4'h5, 1'b1, 1'b0});
    finish_op(-1);
    @(negedge clk);

    // Random ops against the reference model, with random idle gaps
    for (int i = 0; i < 1000; i++) begin
      s = 1'($urandom); av = W'($urandom); bv = W'($urandom);
      issue(s, av, bv, model(s, av, bv));
      finish_op(-1);
      if ($urandom_range(0, 1) == 1) @(negedge clk);
    end

    chk("scoreboard_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
